// File: rtl/char_disp_pkg.sv
// Shared types and constants for the character display path.
// Used by char_row_scanner and row_serializer.
package char_disp_pkg;

    localparam int ROW_BITS = 4;
    localparam int ROWS     = 16;

    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_HOLD_CYCLES = 1000;
    localparam int DEF_CHAR_FRAMES = 50;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_LATCH,
        S_HOLD
    } scan_state_t;

    // Counter width for a modulo-n counter; never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_serializer.sv
// Shifts one glyph row MSB-first onto ser_data with a divided ser_clk.
// Receiver samples on the ser_clk rising edge; ser_clk idles low.
module row_serializer
    import char_disp_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] din,
    input  logic                 start,
    output logic                 busy,
    output logic                 ser_clk,
    output logic                 ser_data
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int BIT_W = cnt_w(DATAWIDTH);

    logic [DATAWIDTH-1:0] sh_q, sh_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 run_q, run_d;
    logic                 sclk_q, sclk_d;
    logic                 sdat_q, sdat_d;
    logic                 div_end, last;

    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign last    = run_q && sclk_q && div_end && (bit_q == BIT_W'(DATAWIDTH - 1));
    // Drops during the final shift cycle so the caller can leave on that edge.
    assign busy     = run_q && !last;
    assign ser_clk  = sclk_q;
    assign ser_data = sdat_q;

    always_comb begin
        sh_d   = sh_q;
        div_d  = div_q;
        bit_d  = bit_q;
        run_d  = run_q;
        sclk_d = sclk_q;
        sdat_d = sdat_q;
        if (load) sh_d = din;
        if (start) begin
            run_d  = 1'b1;
            div_d  = '0;
            bit_d  = '0;
            sclk_d = 1'b0;
            sdat_d = load ? din[DATAWIDTH-1] : sh_q[DATAWIDTH-1];
        end else if (run_q) begin
            if (!div_end) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (last) begin
                        run_d = 1'b0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sh_d   = {sh_q[DATAWIDTH-2:0], 1'b0};
                        sdat_d = sh_q[DATAWIDTH-2];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            div_q  <= '0;
            bit_q  <= '0;
            run_q  <= 1'b0;
            sclk_q <= 1'b0;
            sdat_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            run_q  <= run_d;
            sclk_q <= sclk_d;
            sdat_q <= sdat_d;
        end
    end

endmodule

// File: rtl/char_row_scanner.sv
// Font BRAM row scanner: fetches glyph rows, serialises them to the column chain,
// latches and drives the row select. Optional LED_OE_EN adds an active-low output enable.
module char_row_scanner
    import char_disp_pkg::*;
#(
    parameter int MEMWIDTH    = 8,
    parameter int DATAWIDTH   = 16,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CHAR_FRAMES = DEF_CHAR_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [MEMWIDTH-1:0]  raddr,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic                 ser_clk,
    output logic                 ser_data,
    output logic                 ser_latch,
    output logic [ROWS-1:0]      row_sel,
    output logic                 frame_done
`ifdef LED_OE_EN
    , output logic               oe_n
`endif
);

    localparam int CHAR_W = MEMWIDTH - ROW_BITS;
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int FRM_W  = cnt_w(CHAR_FRAMES);

    scan_state_t         state_q, state_d;
    logic [MEMWIDTH-1:0] raddr_q, raddr_d;
    logic [ROWS-1:0]     row_sel_q, row_sel_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                latch_q, latch_d;
    logic                fdone_q, fdone_d;
    logic                ser_go, ser_busy, hold_end;

    assign ser_go   = (state_q == S_WAIT);
    assign hold_end = (state_q == S_HOLD) && (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    row_serializer #(
        .DATAWIDTH (DATAWIDTH),
        .CLK_DIV   (CLK_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_go),
        .din      (rdata),
        .start    (ser_go),
        .busy     (ser_busy),
        .ser_clk  (ser_clk),
        .ser_data (ser_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_SHIFT;
            S_SHIFT: if (!ser_busy) state_d = S_LATCH;
            S_LATCH: state_d = S_HOLD;
            S_HOLD:  if (hold_end) state_d = en ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        raddr_d   = raddr_q;
        row_sel_d = row_sel_q;
        row_d     = row_q;
        char_d    = char_q;
        frm_d     = frm_q;
        hold_d    = '0;
        latch_d   = 1'b0;
        fdone_d   = 1'b0;
        case (state_q)
            S_IDLE: if (en) raddr_d = {char_q, row_q};
            S_SHIFT: begin
                if (!ser_busy) begin
                    latch_d   = 1'b1;
                    row_sel_d = ROWS'(1) << row_q;
                end
            end
            S_HOLD: begin
                if (!hold_end) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_BITS'(ROWS - 1)) begin
                        fdone_d = 1'b1;
                        if (frm_q == FRM_W'(CHAR_FRAMES - 1)) begin
                            frm_d  = '0;
                            char_d = char_q + 1'b1;
                        end else begin
                            frm_d = frm_q + 1'b1;
                        end
                    end
                    raddr_d = {char_d, row_d};
                    if (!en) row_sel_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q   <= '0;
            row_sel_q <= '0;
            row_q     <= '0;
            char_q    <= '0;
            frm_q     <= '0;
            hold_q    <= '0;
            latch_q   <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            raddr_q   <= raddr_d;
            row_sel_q <= row_sel_d;
            row_q     <= row_d;
            char_q    <= char_d;
            frm_q     <= frm_d;
            hold_q    <= hold_d;
            latch_q   <= latch_d;
            fdone_q   <= fdone_d;
        end
    end

    assign raddr      = raddr_q;
    assign row_sel    = row_sel_q;
    assign ser_latch  = latch_q;
    assign frame_done = fdone_q;

`ifdef LED_OE_EN
    logic oe_n_q;
    // Blank everywhere except while the freshly latched row is being held.
    always_ff @(posedge clk) begin
        if (rst) oe_n_q <= 1'b1;
        else     oe_n_q <= (state_d != S_HOLD);
    end
    assign oe_n = oe_n_q;
`endif

endmodule

// File: tb/tb_char_row_scanner.sv
// Bench for char_row_scanner: random font contents, row/frame/char sequencing
// model derived from the row count, en drop and mid-row reset scenarios.
module tb_char_row_scanner;

    localparam int MW    = 8;
    localparam int DW    = 16;
    localparam int CD    = 2;
    localparam int HC    = 8;
    localparam int CF    = 2;
    localparam int ROW_T = 3 + 32 * CD + HC;
    localparam int LAT   = 2 + 32 * CD;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [MW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          ser_clk, ser_data, ser_latch, frame_done;
    logic [15:0]   row_sel;
`ifdef LED_OE_EN
    logic          oe_n;
`endif

    logic [DW-1:0] mem [256];
    int errors = 0, checks = 0, cyc = 0;
    int n_rows, last_latch, last_row, last_fd, nbits, fc, keep_n;
    bit have_latch, en_gap, fd_gap;
    logic [DW-1:0] bits;
    logic prev_sclk;

    char_row_scanner #(
        .MEMWIDTH    (MW),
        .DATAWIDTH   (DW),
        .CLK_DIV     (CD),
        .HOLD_CYCLES (HC),
        .CHAR_FRAMES (CF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .raddr      (raddr),
        .rdata      (rdata),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .row_sel    (row_sel),
        .frame_done (frame_done)
`ifdef LED_OE_EN
        , .oe_n     (oe_n)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    function automatic int exp_addr(input int n);
        return ((n / (16 * CF)) % 16) * 16 + (n % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            n_rows = 0; have_latch = 0; nbits = 0; en_gap = 1; fd_gap = 1;
        end
        if (!en) begin en_gap = 1; fd_gap = 1; end
        if (ser_clk && !prev_sclk) begin
            bits = {bits[DW-2:0], ser_data};
            nbits++;
        end
        prev_sclk = ser_clk;
        if (ser_latch) begin
            chk("latch_bits", 32'(nbits), 32'd16);
            chk("row_data", 32'(bits), 32'(mem[exp_addr(n_rows)]));
            chk("raddr", 32'(raddr), 32'(exp_addr(n_rows)));
            chk("row_sel", 32'(row_sel), 32'(1) << (n_rows % 16));
            if (have_latch && !en_gap) chk("latch_gap", 32'(cyc - last_latch), 32'(ROW_T));
            last_latch = cyc; last_row = n_rows % 16; have_latch = 1; en_gap = 0; nbits = 0;
            n_rows++;
        end
        chk("frame_done", 32'(frame_done),
            32'(have_latch && last_row == 15 && cyc == last_latch + HC + 1));
        if (frame_done) begin
            if (!fd_gap) chk("frame_gap", 32'(cyc - last_fd), 32'(16 * ROW_T));
            last_fd = cyc; fd_gap = 0;
        end
`ifdef LED_OE_EN
        chk("oe_n", 32'(oe_n), 32'(!(have_latch && cyc > last_latch && cyc <= last_latch + HC)));
`endif
    endtask

    task automatic run_rows(input int target, input int budget);
        int c = 0;
        while (n_rows < target && c < budget) begin
            step();
            c++;
        end
        chk("rows_reached", 32'(n_rows >= target), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_raddr"}, 32'(raddr), 32'd0);
        chk({tag, "_sclk"}, 32'(ser_clk), 32'd0);
        chk({tag, "_sdat"}, 32'(ser_data), 32'd0);
        chk({tag, "_latch"}, 32'(ser_latch), 32'd0);
        chk({tag, "_rowsel"}, 32'(row_sel), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
`ifdef LED_OE_EN
        chk({tag, "_oe_n"}, 32'(oe_n), 32'd1);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;
        rst = 1; en = 1; prev_sclk = 0; bits = '0; nbits = 0; n_rows = 0;
        have_latch = 0; en_gap = 1; fd_gap = 1; last_latch = 0; last_row = 0; last_fd = 0;

        repeat (3) step();
        chk_reset_outs("reset");

        // First edge after reset release enters FETCH.
        rst = 0;
        step();
        fc = cyc;
        run_rows(1, 200);
        chk("first_latency", 32'(last_latch - fc), 32'(LAT));
        chk("row0_pattern", 32'(bits), 32'hA5C3);
        chk("row0_sel", 32'(row_sel), 32'h0001);

        run_rows(16, 16 * 80);
        chk("row15_raddr", 32'(raddr), 32'h0F);
        run_rows(33, 17 * 80);
        chk("char_adv", 32'(raddr), 32'h10);

        // Drop en in the middle of a row's shift phase.
        repeat ($urandom_range(70, 12)) step();
        en = 0;
        keep_n = n_rows;
        run_rows(keep_n + 1, 100);
        repeat (20) step();
        chk("idle_rowsel", 32'(row_sel), 32'd0);
        chk("idle_sclk", 32'(ser_clk), 32'd0);
        keep_n = n_rows;
        repeat (100) step();
        chk("idle_no_latch", 32'(n_rows), 32'(keep_n));
        en = 1;
        step();
        fc = cyc;
        run_rows(keep_n + 1, 200);
        chk("resume_latency", 32'(last_latch - fc), 32'(LAT));

        run_rows(16 * 16 * CF, 40000);
        chk("last_char_row", 32'(raddr), 32'hFF);
        run_rows(16 * 16 * CF + 1, 100);
        chk("char_wrap", 32'(raddr), 32'h00);

        // Reset in the middle of a shift: no latch may follow.
        repeat ($urandom_range(70, 12)) step();
        rst = 1;
        step();
        chk_reset_outs("midreset");
        step();
        chk_reset_outs("midreset2");
        rst = 0;
        step();
        fc = cyc;
        run_rows(1, 200);
        chk("restart_latency", 32'(last_latch - fc), 32'(LAT));
        chk("restart_pattern", 32'(bits), 32'hA5C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_row_scanner.md
Name: char_row_scanner

Overview:
- Downstream consumer of the font BRAM in the character display path.
- Generates the BRAM read address ({char_idx, row_idx}) and captures each 16-bit glyph row.
- Serialises each row MSB-first to an external 74HC595-style column shift-register chain, then latches it and drives the matching LED matrix row select.
- Advances through all 16 rows continuously and steps to the next character after a programmable number of frames.

Parameters:
- MEMWIDTH, 8, BRAM address width; the upper MEMWIDTH-4 bits are char_idx, the lower 4 bits are row_idx.
- DATAWIDTH, 16, glyph row width = number of serial bits per row.
- CLK_DIV, 4, sys clocks per ser_clk half-period; must be >= 1.
- HOLD_CYCLES, 1000, sys clocks each row stays lit; must be >= 1.
- CHAR_FRAMES, 50, full 16-row frames shown per character before char_idx advances; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- raddr  out  MEMWIDTH  BRAM read address (registered).
- rdata  in  DATAWIDTH  BRAM read data; valid one clock after raddr is sampled.
- ser_clk  out  1  serial shift clock to the column chain.
- ser_data  out  1  serial column bit.
- ser_latch  out  1  one-cycle storage-register latch pulse.
- row_sel  out  16  one-hot active-high row drive.
- frame_done  out  1  one-cycle pulse when row 15 finishes HOLD.

Behaviour:
- Reset: state IDLE. All of the following are 0: raddr, ser_clk, ser_data, ser_latch, row_sel, frame_done, row_idx, char_idx, frame counter.
- Reset is synchronous and overrides any state mid-row; no partial latch is issued after it.
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH, HOLD.
- IDLE -> FETCH when en=1. raddr is loaded with {char_idx,row_idx} on that edge.
- FETCH (1 cycle): the BRAM samples raddr.
- WAIT (1 cycle): rdata is valid. The shift register loads rdata on the edge leaving WAIT.
- SHIFT:
  - 16 bits sent, MSB first.
  - Per bit: ser_data is set with ser_clk low for CLK_DIV cycles, then ser_clk is high for CLK_DIV cycles. The receiver samples on the ser_clk rising edge.
  - Length: 2*CLK_DIV*16 cycles. ser_clk ends low.
- LATCH (1 cycle): ser_latch=1, and row_sel becomes (1<<row_idx) on the same edge.
- HOLD: HOLD_CYCLES cycles, then:
  - row_idx increments (15 wraps to 0).
  - On the wrap: frame_done pulses and the frame counter increments.
  - When the frame counter reaches CHAR_FRAMES, it clears and char_idx increments, wrapping at 2^(MEMWIDTH-4).
  - Next state is FETCH if en=1, else IDLE with row_sel=0.
- en is sampled only in IDLE and at the end of HOLD. Deasserting it mid-row completes that row.
- Row period = 1+1+32*CLK_DIV+1+HOLD_CYCLES cycles.
- Counters are sized with $clog2 of their terminal values. No arithmetic overflow is possible beyond the explicit wraps above.

Optional Feature:
- LED_OE_EN defined: adds output oe_n (1 bit).
  - oe_n=1 (blank) from entering FETCH through the LATCH cycle, and =0 only during HOLD.
  - Reset value 1.
- LED_OE_EN undefined: port and logic absent. row_sel alone gates the display, so ghosting during SHIFT is accepted.

Decomposition:
- Package char_disp_pkg holds:
  - the state enum (scan_state_t);
  - ROW_BITS=4 and ROWS=16;
  - the default CLK_DIV, HOLD_CYCLES and CHAR_FRAMES constants, shared with the display top.
- One sub-module, row_serializer:
  - owns the DATAWIDTH shift register, the CLK_DIV divider and the bit counter;
  - interface: load, din, start, busy, ser_clk, ser_data.

Test Plan (CLK_DIV=2, HOLD_CYCLES=8, CHAR_FRAMES=2; BRAM model with 1-cycle latency, rdata=16'hA5C3 at address 0x00):
- Reset check: rst=1 for 3 cycles with en=1 -> all outputs 0; FETCH is entered on the first edge after rst falls.
- Row 0 serialisation: en=1 -> raddr=0x00; ser_data sequence on ser_clk rising edges is 1010010111000011; ser_latch pulses exactly 66 cycles after FETCH entry; row_sel=16'h0001.
- Timing: consecutive ser_latch pulses are 75 cycles apart; raddr steps 0x00..0x0F.
- Frame and char advance: frame_done pulses every 1200 cycles; after 2 frames raddr=0x10. At char_idx=15, row 15, the wrap gives raddr=0x00.
- en deassert mid-SHIFT -> the row finishes (latch + HOLD), then IDLE with row_sel=0; re-asserting en resumes at the next row_idx.
- rst asserted mid-SHIFT -> next edge all outputs 0 with no ser_latch. With LED_OE_EN: oe_n=1 except during the 8 HOLD cycles.
